sram_req_arbiter: RTL and testbench
===================================

# sram_req_arbiter

Shares the CPU's single SRAM-like memory port between the instruction-fetch requester and the data requester, which issues loads and stores for the MEM stage. The block sits between the pipeline's two SRAM-like interfaces and the SRAM-to-AXI bridge. It grants one request per handshake, records which requester owns each outstanding transaction, and returns every `data_ok`/`rdata` to its owner in issue order.

## Interface
- `DEPTH`, 2: maximum outstanding (address-accepted, data-not-returned) transactions; power of two, 2..8.
- `clk`  in  1  clock; all state updates on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `inst_req` / `inst_wr` / `inst_size`[1:0] / `inst_addr`[31:0] / `inst_wstrb`[3:0] / `inst_wdata`[31:0]  in  request from the fetch side.
- `inst_addr_ok`  out  1  fetch request accepted this cycle.
- `inst_data_ok`  out  1  fetch response this cycle.
- `inst_rdata`  out  32  fetch response data.
- `data_req` / `data_wr` / `data_size`[1:0] / `data_addr`[31:0] / `data_wstrb`[3:0] / `data_wdata`[31:0]  in  request from the data side.
- `data_addr_ok`  out  1  data request accepted this cycle.
- `data_data_ok`  out  1  data response this cycle.
- `data_rdata`  out  32  data response data.
- `m_req` / `m_wr` / `m_size`[1:0] / `m_addr`[31:0] / `m_wstrb`[3:0] / `m_wdata`[31:0]  out  request to the bridge.
- `m_addr_ok`  in  1  bridge accepted the request.
- `m_data_ok`  in  1  bridge response.
- `m_rdata`  in  32  bridge response data.
- `resp_err`  out  1  sticky flag: `m_data_ok` arrived with no outstanding transaction.

## Operation
- Owner FIFO: `DEPTH` entries of 1 bit each (0 = inst, 1 = data), with write pointer, read pointer and a `count` register of width clog2(DEPTH)+1.
- `full` = (`count` == `DEPTH`). `empty` = (`count` == 0).
- Grant selection:
  - If `hold_valid` is set, the grant is `hold_owner`.
  - Otherwise data has priority: grant data if `data_req`, else inst if `inst_req`.
- `m_req` = granted requester's req & ~`full`. All other `m_*` request fields mux from the granted requester. When nothing is granted, fields are 0.
- `<owner>_addr_ok` = `m_addr_ok` & `m_req` & (grant == owner). The non-granted requester's `addr_ok` is 0.
- Push: on `m_req` & `m_addr_ok`, write the granted owner at the write pointer and increment the pointer, wrapping modulo `DEPTH`.
- Hold register:
  - Set `hold_valid` and `hold_owner` when `m_req` is 1 and `m_addr_ok` is 0. A presented request must not change until it is accepted.
  - Clear `hold_valid` on acceptance.
  - `full` does not set the hold, because no `m_req` is driven while full.
- Response routing:
  - `inst_data_ok` = `m_data_ok` & ~`empty` & (head == 0).
  - `data_data_ok` = `m_data_ok` & ~`empty` & (head == 1).
  - Both `rdata` outputs are driven by `m_rdata` unconditionally.
- Pop: on `m_data_ok` & ~`empty`, increment the read pointer, wrapping.
- Simultaneous push and pop: `count` is unchanged and both pointers advance.
- Full handling: `full` blocks `m_req` even if a pop occurs in the same cycle. This is deliberate; it keeps `m_data_ok` off the request path.
- Response with no outstanding transaction: `m_data_ok` while `empty` sets `resp_err`. No `data_ok` is forwarded and pointers are unchanged. `resp_err` clears only on reset.
- Stores push an owner entry like loads do. The bridge returns `data_ok` for writes.

## Timing
- Reset (`resetn` = 0, asynchronous): `count`, pointers, `hold_valid` and `resp_err` go to 0. All `*_addr_ok`, `*_data_ok` and `m_req` go to 0.
- Release of reset takes effect on the next rising edge.
- Outputs are combinational from the inputs and current state. Request-to-`m_req` latency is 0 cycles. `data_ok` forwarding latency is 0 cycles.
- `m_req` depends on `full` and grant state only, never on `m_data_ok` or `m_addr_ok`.
- Full throughput: one acceptance per cycle while not full. Back-to-back push and pop sustains `count` = `DEPTH` − 1.
- Reset mid-transaction drops all outstanding ownership. The bridge must be reset in the same domain.

## Test plan
- Single fetch: `inst_req` = 1 at addr 0x1C000000, `m_addr_ok` = 1 in cycle 0, `m_data_ok` = 1 with rdata 0x02800000 in cycle 2. Required: `inst_addr_ok` in cycle 0, `inst_data_ok` with `inst_rdata` = 0x02800000 in cycle 2, `data_data_ok` stays 0.
- Conflict: `inst_req` and `data_req` both asserted with `m_addr_ok` = 1. Required: data is granted first, inst is granted the next cycle, and responses return data-owned then inst-owned.
- Hold: `inst_req` alone with `m_addr_ok` = 0 for 3 cycles, and `data_req` rises in cycle 1. Required: `m_addr` stays at the inst address until accepted in cycle 3, and data is granted in cycle 4.
- Full (`DEPTH` = 2): two accepted requests, no responses, third request pending. Required: `m_req` = 0. `m_data_ok` in cycle N gives the matching owner's `data_ok`, and `m_req` = 1 in cycle N+1.
- Simultaneous: `count` = 1, push and pop in the same cycle. Required: `count` stays 1 and the wrap-around pointers route the next response to the newly pushed owner.
- Spurious response: `m_data_ok` = 1 while empty. Required: `resp_err` = 1 and stays 1, no `data_ok` is forwarded, and `resetn` pulse 0 clears it asynchronously.

Source files
------------

// File: rtl/sram_req_arbiter_if.sv
// SRAM-like request/response bundle: one instance per pipeline side and one toward the bridge.
// The master drives the request fields; the slave answers with addr_ok/data_ok/rdata.
interface sram_req_arbiter_if;
   logic        req;
   logic        wr;
   logic [1:0]  size;
   logic [31:0] addr;
   logic [3:0]  wstrb;
   logic [31:0] wdata;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] rdata;

   modport master (
      output req, wr, size, addr, wstrb, wdata,
      input  addr_ok, data_ok, rdata
   );

   modport slave (
      input  req, wr, size, addr, wstrb, wdata,
      output addr_ok, data_ok, rdata
   );
endinterface

// File: rtl/sram_req_arbiter.sv
// Shares one SRAM-like port between fetch and data requesters; an owner FIFO
// tags each accepted transaction so responses return to their issuer in order.
module sram_req_arbiter #(
   parameter int DEPTH = 2
) (
   input  logic               clk,
   input  logic               resetn,
   sram_req_arbiter_if.slave  inst,
   sram_req_arbiter_if.slave  data,
   sram_req_arbiter_if.master m,
   output logic               resp_err
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic          owner_mem [DEPTH];
   logic [PW-1:0] wr_ptr_reg;
   logic [PW-1:0] rd_ptr_reg;
   logic [CW-1:0] count_reg;
   logic          hold_valid_reg;
   logic          hold_owner_reg;
   logic          resp_err_reg;

   logic full;
   logic empty;
   logic gnt_valid;
   logic gnt_owner;
   logic gnt_req;
   logic push;
   logic pop;
   logic head;

   assign full  = (count_reg == CW'(DEPTH));
   assign empty = (count_reg == '0);

   // A presented-but-unaccepted request pins the grant until the bridge takes it.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_owner = 1'b0;
      if (hold_valid_reg) begin
         gnt_valid = 1'b1;
         gnt_owner = hold_owner_reg;
      end else if (data.req) begin
         gnt_valid = 1'b1;
         gnt_owner = 1'b1;
      end else if (inst.req) begin
         gnt_valid = 1'b1;
         gnt_owner = 1'b0;
      end
   end

   assign gnt_req = gnt_valid & (gnt_owner ? data.req : inst.req);
   // Deliberately independent of m.data_ok: a same-cycle pop does not unblock full.
   assign m.req   = gnt_req & ~full & resetn;

   always_comb begin
      m.wr    = 1'b0;
      m.size  = '0;
      m.addr  = '0;
      m.wstrb = '0;
      m.wdata = '0;
      if (gnt_valid) begin
         if (gnt_owner) begin
            m.wr    = data.wr;
            m.size  = data.size;
            m.addr  = data.addr;
            m.wstrb = data.wstrb;
            m.wdata = data.wdata;
         end else begin
            m.wr    = inst.wr;
            m.size  = inst.size;
            m.addr  = inst.addr;
            m.wstrb = inst.wstrb;
            m.wdata = inst.wdata;
         end
      end
   end

   assign push = m.req & m.addr_ok;
   assign pop  = m.data_ok & ~empty;
   assign head = owner_mem[rd_ptr_reg];

   assign inst.addr_ok = push & gnt_valid & ~gnt_owner;
   assign data.addr_ok = push & gnt_valid & gnt_owner;
   assign inst.data_ok = pop & ~head;
   assign data.data_ok = pop & head;
   assign inst.rdata   = m.rdata;
   assign data.rdata   = m.rdata;
   assign resp_err     = resp_err_reg;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_reg     <= '0;
         rd_ptr_reg     <= '0;
         count_reg      <= '0;
         hold_valid_reg <= 1'b0;
         hold_owner_reg <= 1'b0;
         resp_err_reg   <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + PW'(1);
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + PW'(1);
         end
         case ({push, pop})
            2'b10:   count_reg <= count_reg + CW'(1);
            2'b01:   count_reg <= count_reg - CW'(1);
            default: count_reg <= count_reg;
         endcase
         if (push) begin
            hold_valid_reg <= 1'b0;
         end else if (m.req) begin
            hold_valid_reg <= 1'b1;
            hold_owner_reg <= gnt_owner;
         end
         if (m.data_ok && empty) begin
            resp_err_reg <= 1'b1;
         end
      end
   end

   // Owner storage needs no reset: entries are only read while count is nonzero.
   always_ff @(posedge clk) begin
      if (push) begin
         owner_mem[wr_ptr_reg] <= gnt_owner;
      end
   end
endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed bench for sram_req_arbiter (DEPTH = 2): reset, single fetch, conflict,
// hold, full, simultaneous push/pop with wrap, and spurious response handling.
module tb_sram_req_arbiter;
   logic clk;
   logic resetn;
   logic resp_err;
   int   checks;
   int   errors;

   sram_req_arbiter_if inst_bus ();
   sram_req_arbiter_if data_bus ();
   sram_req_arbiter_if m_bus ();

   sram_req_arbiter #(.DEPTH(2)) dut (
      .clk      (clk),
      .resetn   (resetn),
      .inst     (inst_bus),
      .data     (data_bus),
      .m        (m_bus),
      .resp_err (resp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One line per bus transaction, sampled mid-cycle.
   always @(negedge clk) begin
      if (resetn && m_bus.req && m_bus.addr_ok)
         $display("txn req  addr=%h wr=%0d", m_bus.addr, m_bus.wr);
      if (resetn && m_bus.data_ok)
         $display("txn resp rdata=%h inst_ok=%0d data_ok=%0d", m_bus.rdata, inst_bus.data_ok, data_bus.data_ok);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      inst_bus.req = 1'b0; inst_bus.wr = 1'b0; inst_bus.size = 2'd2;
      inst_bus.addr = '0; inst_bus.wstrb = '0; inst_bus.wdata = '0;
      data_bus.req = 1'b0; data_bus.wr = 1'b0; data_bus.size = 2'd2;
      data_bus.addr = '0; data_bus.wstrb = '0; data_bus.wdata = '0;
      m_bus.addr_ok = 1'b0; m_bus.data_ok = 1'b0; m_bus.rdata = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      resetn = 1'b1;
      idle();
      #1 resetn = 1'b0;

      // Reset: outputs quiet even with activity on the inputs
      inst_bus.req = 1'b1; inst_bus.addr = 32'h1C00_0000;
      m_bus.addr_ok = 1'b1; m_bus.data_ok = 1'b1;
      #2;
      chk("rst_m_req", m_bus.req, 1'b0);
      chk("rst_inst_addr_ok", inst_bus.addr_ok, 1'b0);
      chk("rst_inst_data_ok", inst_bus.data_ok, 1'b0);
      chk("rst_data_data_ok", data_bus.data_ok, 1'b0);
      chk("rst_resp_err", resp_err, 1'b0);
      tick();
      chk("rst_m_req_edge", m_bus.req, 1'b0);
      idle();
      resetn = 1'b1;
      tick();

      // Single fetch
      idle(); inst_bus.req = 1'b1; inst_bus.addr = 32'h1C00_0000; m_bus.addr_ok = 1'b1; #1;
      chk("sf_m_req", m_bus.req, 1'b1);
      chk("sf_m_addr", m_bus.addr, 32'h1C00_0000);
      chk("sf_inst_addr_ok", inst_bus.addr_ok, 1'b1);
      chk("sf_data_addr_ok", data_bus.addr_ok, 1'b0);
      tick();
      idle(); #1;
      chk("sf_c1_inst_data_ok", inst_bus.data_ok, 1'b0);
      tick();
      idle(); m_bus.data_ok = 1'b1; m_bus.rdata = 32'h0280_0000; #1;
      chk("sf_inst_data_ok", inst_bus.data_ok, 1'b1);
      chk("sf_inst_rdata", inst_bus.rdata, 32'h0280_0000);
      chk("sf_data_data_ok", data_bus.data_ok, 1'b0);
      tick();

      // Conflict: data wins, inst follows, responses in issue order
      idle(); inst_bus.req = 1'b1; inst_bus.addr = 32'h1C00_0004;
      data_bus.req = 1'b1; data_bus.addr = 32'h8000_1000; m_bus.addr_ok = 1'b1; #1;
      chk("cf_m_addr0", m_bus.addr, 32'h8000_1000);
      chk("cf_data_addr_ok0", data_bus.addr_ok, 1'b1);
      chk("cf_inst_addr_ok0", inst_bus.addr_ok, 1'b0);
      tick();
      idle(); inst_bus.req = 1'b1; inst_bus.addr = 32'h1C00_0004; m_bus.addr_ok = 1'b1; #1;
      chk("cf_m_addr1", m_bus.addr, 32'h1C00_0004);
      chk("cf_inst_addr_ok1", inst_bus.addr_ok, 1'b1);
      tick();
      idle(); m_bus.data_ok = 1'b1; m_bus.rdata = 32'h1111_1111; #1;
      chk("cf_resp0_data_ok", data_bus.data_ok, 1'b1);
      chk("cf_resp0_inst_ok", inst_bus.data_ok, 1'b0);
      chk("cf_resp0_rdata", data_bus.rdata, 32'h1111_1111);
      tick();
      idle(); m_bus.data_ok = 1'b1; m_bus.rdata = 32'h2222_2222; #1;
      chk("cf_resp1_inst_ok", inst_bus.data_ok, 1'b1);
      chk("cf_resp1_data_ok", data_bus.data_ok, 1'b0);
      tick();

      // Hold: inst stalled three cycles, data arrives meanwhile
      idle(); inst_bus.req = 1'b1; inst_bus.addr = 32'h1C00_0008; #1;
      chk("hd_c0_m_req", m_bus.req, 1'b1);
      chk("hd_c0_m_addr", m_bus.addr, 32'h1C00_0008);
      chk("hd_c0_inst_addr_ok", inst_bus.addr_ok, 1'b0);
      tick();
      for (int c = 1; c <= 2; c++) begin
         idle(); inst_bus.req = 1'b1; inst_bus.addr = 32'h1C00_0008;
         data_bus.req = 1'b1; data_bus.addr = 32'h8000_2000; #1;
         chk("hd_stall_m_addr", m_bus.addr, 32'h1C00_0008);
         chk("hd_stall_data_addr_ok", data_bus.addr_ok, 1'b0);
         tick();
      end
      idle(); inst_bus.req = 1'b1; inst_bus.addr = 32'h1C00_0008;
      data_bus.req = 1'b1; data_bus.addr = 32'h8000_2000; m_bus.addr_ok = 1'b1; #1;
      chk("hd_c3_m_addr", m_bus.addr, 32'h1C00_0008);
      chk("hd_c3_inst_addr_ok", inst_bus.addr_ok, 1'b1);
      chk("hd_c3_data_addr_ok", data_bus.addr_ok, 1'b0);
      tick();
      idle(); data_bus.req = 1'b1; data_bus.addr = 32'h8000_2000; data_bus.wr = 1'b1;
      data_bus.wstrb = 4'hF; data_bus.wdata = 32'hDEAD_BEEF; m_bus.addr_ok = 1'b1; #1;
      chk("hd_c4_m_addr", m_bus.addr, 32'h8000_2000);
      chk("hd_c4_data_addr_ok", data_bus.addr_ok, 1'b1);
      chk("hd_c4_m_wr", m_bus.wr, 1'b1);
      chk("hd_c4_m_wdata", m_bus.wdata, 32'hDEAD_BEEF);
      chk("hd_c4_m_wstrb", m_bus.wstrb, 4'hF);
      tick();

      // Full: two outstanding (inst, data store); pop does not unblock the same cycle
      idle(); inst_bus.req = 1'b1; inst_bus.addr = 32'h1C00_000C; m_bus.addr_ok = 1'b1;
      m_bus.data_ok = 1'b1; m_bus.rdata = 32'h3333_3333; #1;
      chk("fl_m_req_blocked", m_bus.req, 1'b0);
      chk("fl_inst_addr_ok", inst_bus.addr_ok, 1'b0);
      chk("fl_inst_data_ok", inst_bus.data_ok, 1'b1);
      chk("fl_data_data_ok", data_bus.data_ok, 1'b0);
      tick();
      idle(); inst_bus.req = 1'b1; inst_bus.addr = 32'h1C00_000C; m_bus.addr_ok = 1'b1; #1;
      chk("fl_n1_m_req", m_bus.req, 1'b1);
      chk("fl_n1_m_addr", m_bus.addr, 32'h1C00_000C);
      chk("fl_n1_inst_addr_ok", inst_bus.addr_ok, 1'b1);
      tick();
      idle(); m_bus.data_ok = 1'b1; m_bus.rdata = 32'h4444_4444; #1;
      chk("fl_store_data_ok", data_bus.data_ok, 1'b1);
      chk("fl_store_inst_ok", inst_bus.data_ok, 1'b0);
      tick();

      // Simultaneous push (data) and pop (inst) at count 1
      idle(); data_bus.req = 1'b1; data_bus.addr = 32'h8000_3000; m_bus.addr_ok = 1'b1;
      m_bus.data_ok = 1'b1; m_bus.rdata = 32'h5555_5555; #1;
      chk("sm_m_req", m_bus.req, 1'b1);
      chk("sm_data_addr_ok", data_bus.addr_ok, 1'b1);
      chk("sm_inst_data_ok", inst_bus.data_ok, 1'b1);
      chk("sm_data_data_ok", data_bus.data_ok, 1'b0);
      tick();
      idle(); inst_bus.req = 1'b1; inst_bus.addr = 32'h1C00_0010; m_bus.addr_ok = 1'b1; #1;
      chk("sm_push2_inst_addr_ok", inst_bus.addr_ok, 1'b1);
      tick();
      idle(); inst_bus.req = 1'b1; inst_bus.addr = 32'h1C00_0014; m_bus.addr_ok = 1'b1;
      m_bus.data_ok = 1'b1; m_bus.rdata = 32'h6666_6666; #1;
      chk("sm_full_after_one_push", m_bus.req, 1'b0);
      chk("sm_wrap_data_ok", data_bus.data_ok, 1'b1);
      chk("sm_wrap_inst_ok", inst_bus.data_ok, 1'b0);
      tick();
      idle(); m_bus.data_ok = 1'b1; m_bus.rdata = 32'h7777_7777; #1;
      chk("sm_last_inst_ok", inst_bus.data_ok, 1'b1);
      chk("sm_last_data_ok", data_bus.data_ok, 1'b0);
      tick();

      // Spurious response while empty
      idle(); m_bus.data_ok = 1'b1; m_bus.rdata = 32'h9999_9999; #1;
      chk("sp_inst_data_ok", inst_bus.data_ok, 1'b0);
      chk("sp_data_data_ok", data_bus.data_ok, 1'b0);
      chk("sp_resp_err_pre", resp_err, 1'b0);
      tick();
      idle(); #1;
      chk("sp_resp_err_set", resp_err, 1'b1);
      tick();
      chk("sp_resp_err_sticky", resp_err, 1'b1);
      idle(); inst_bus.req = 1'b1; inst_bus.addr = 32'h1C00_0018; m_bus.addr_ok = 1'b1; #1;
      chk("sp_after_push_ok", inst_bus.addr_ok, 1'b1);
      tick();
      idle(); m_bus.data_ok = 1'b1; m_bus.rdata = 32'hAAAA_AAAA; #1;
      chk("sp_after_inst_ok", inst_bus.data_ok, 1'b1);
      chk("sp_resp_err_still", resp_err, 1'b1);
      tick();

      // Asynchronous clear of resp_err, mid-cycle
      idle();
      resetn = 1'b0;
      #1;
      chk("ar_resp_err_cleared", resp_err, 1'b0);
      tick();
      resetn = 1'b1;
      tick();
      idle(); inst_bus.req = 1'b1; inst_bus.addr = 32'h1C00_001C; #1;
      chk("ar_m_req_after", m_bus.req, 1'b1);
      tick();
      idle();
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
